// File: rtl/branch_resolve.sv
// Branch resolution unit: evaluates register conditions and jumps, computes the
// correct next PC, trains a table of 2-bit predictors and keeps statistics.

module branch_resolve_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_upd,
  input  logic       i_inc,
  output logic [1:0] o_ctr
);
  logic [1:0] r_ctr;

  always_ff @(posedge clk) begin
    if (!rst_n)                        r_ctr <= 2'b01;
    else if (i_upd && i_inc  && r_ctr != 2'b11) r_ctr <= r_ctr + 2'b01;
    else if (i_upd && !i_inc && r_ctr != 2'b00) r_ctr <= r_ctr - 2'b01;
  end

  assign o_ctr = r_ctr;
endmodule

module branch_resolve #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              kill,
  input  logic [2:0]        code,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [PC_W-1:0]   pc,
  input  logic [15:0]       imm,
  input  logic [PC_W-1:0]   jump_target,
  input  logic              pred_in,
  output logic              out_valid,
  output logic              taken,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_BEQ  = 3'b001;
  localparam logic [2:0] C_BNE  = 3'b010;
  localparam logic [2:0] C_BLEZ = 3'b011;
  localparam logic [2:0] C_BGTZ = 3'b100;
  localparam logic [2:0] C_BLTZ = 3'b101;
  localparam logic [2:0] C_BGEZ = 3'b110;
  localparam logic [2:0] C_JUMP = 3'b111;

  logic                           w_accept, w_jump, w_upd;
  logic                           w_taken, w_mispred;
  logic                           w_eq, w_neg, w_zero;
  logic [PC_W-1:0]                w_seq, w_off, w_target, w_next;
  logic [IDX_W-1:0]               w_upd_idx, w_fetch_idx;
  logic [BHT_DEPTH-1:0][1:0]      w_ctr;
  logic                           w_unused;

  assign w_accept = in_valid & ~stall & ~kill & (code != C_NONE);
  assign w_jump   = (code == C_JUMP);
  assign w_upd    = w_accept & ~w_jump;

  assign w_eq   = (rs_val == rt_val);
  assign w_neg  = rs_val[DATA_W-1];
  assign w_zero = (rs_val == '0);

  always_comb begin
    w_taken = 1'b0;
    case (code)
      C_BEQ:   w_taken = w_eq;
      C_BNE:   w_taken = ~w_eq;
      C_BLEZ:  w_taken = w_neg | w_zero;
      C_BGTZ:  w_taken = ~w_neg & ~w_zero;
      C_BLTZ:  w_taken = w_neg;
      C_BGEZ:  w_taken = ~w_neg;
      C_JUMP:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  // Fetch never predicts jumps, so every jump is a redirect.
  assign w_mispred = w_jump | (w_taken != pred_in);

  // Offset is a word count; sign-extend then scale, wrapping modulo 2^PC_W.
  assign w_off    = PC_W'($signed({imm, 2'b00}));
  assign w_seq    = pc + PC_W'(4);
  assign w_target = w_seq + w_off;
  assign w_next   = w_jump ? jump_target : (w_taken ? w_target : w_seq);

  assign w_upd_idx   = pc[IDX_W+1:2];
  assign w_fetch_idx = fetch_pc[IDX_W+1:2];

  // Counters update at the edge, so a same-cycle lookup sees the old value.
  for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
    branch_resolve_ctr u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_upd (w_upd && (w_upd_idx == IDX_W'(g))),
      .i_inc (w_taken),
      .o_ctr (w_ctr[g])
    );
  end

  assign pred_taken = w_ctr[w_fetch_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      taken            <= 1'b0;
      redirect         <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      out_valid <= w_accept;
      redirect  <= w_accept & w_mispred;
      if (w_accept) begin
        taken       <= w_taken;
        redirect_pc <= w_next;
        if (branch_count != '1) branch_count <= branch_count + CNT_W'(1);
        if (w_mispred && mispredict_count != '1)
          mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  assign w_unused = ^{fetch_pc, pc};
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve; a second instance with CNT_W=2 shares the
// stimulus to exercise counter saturation.

module tb_branch_resolve;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        in_valid, stall, kill, pred_in;
  logic [2:0]  code;
  logic [31:0] rs_val, rt_val, pc, jump_target;
  logic [15:0] imm;

  logic        pred_taken, out_valid, taken, redirect;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  logic        s_pred_taken, s_out_valid, s_taken, s_redirect;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_branch_count, s_mispredict_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .in_valid(in_valid), .stall(stall), .kill(kill), .code(code),
    .rs_val(rs_val), .rt_val(rt_val), .pc(pc), .imm(imm),
    .jump_target(jump_target), .pred_in(pred_in), .out_valid(out_valid),
    .taken(taken), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolve #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(s_pred_taken),
    .in_valid(in_valid), .stall(stall), .kill(kill), .code(code),
    .rs_val(rs_val), .rt_val(rt_val), .pc(pc), .imm(imm),
    .jump_target(jump_target), .pred_in(pred_in), .out_valid(s_out_valid),
    .taken(s_taken), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt,
                    input logic [31:0] p, input logic [15:0] im, input logic pi);
    in_valid = 1'b1; code = c; rs_val = rs; rt_val = rt; pc = p; imm = im; pred_in = pi;
  endtask

  task automatic out(input string tag, input logic v, input logic t, input logic r,
                     input logic [31:0] rpc, input logic [31:0] bc, input logic [31:0] mc);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".taken"}, {31'd0, taken}, {31'd0, t});
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, r});
    chk({tag, ".redirect_pc"}, redirect_pc, rpc);
    chk({tag, ".branch_count"}, {16'd0, branch_count}, bc);
    chk({tag, ".mispredict_count"}, {16'd0, mispredict_count}, mc);
  endtask

  task automatic pred(input string tag, input logic [31:0] fpc, input logic exp);
    fetch_pc = fpc;
    #1;
    chk(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; fetch_pc = 32'h40; in_valid = 1'b0; stall = 1'b0; kill = 1'b0;
    code = 3'b000; rs_val = '0; rt_val = '0; pc = '0; imm = '0; jump_target = '0;
    pred_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    pred("reset.pred", 32'h40, 1'b0);
    out("reset", 0, 0, 0, 32'h0, 0, 0);

    // beq taken, backward offset, predicted not-taken
    br(3'b001, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 16'hFFFE, 1'b0);
    tick();
    out("beq1", 1, 1, 1, 32'hFC, 1, 1);
    tick();
    tick();
    in_valid = 1'b0;
    out("beq3", 1, 1, 1, 32'hFC, 3, 3);
    chk("beq3.s_mispredict", {30'd0, s_mispredict_count}, 32'd3);
    pred("beq3.pred_sat", 32'h100, 1'b1);

    // bne with equal operands: not taken, predicted taken
    br(3'b010, 32'h5, 32'h5, 32'h100, 16'h0004, 1'b1);
    tick();
    in_valid = 1'b0;
    out("bne_nt", 1, 0, 1, 32'h104, 4, 4);
    chk("bne_nt.s_mispredict_sat", {30'd0, s_mispredict_count}, 32'd3);
    pred("bne_nt.pred_weak", 32'h100, 1'b1);

    br(3'b101, 32'h80000000, 32'h0, 32'h200, 16'h0010, 1'b1);
    tick();
    out("bltz", 1, 1, 0, 32'h244, 5, 4);

    br(3'b100, 32'h0, 32'h0, 32'h300, 16'h0010, 1'b0);
    tick();
    out("bgtz", 1, 0, 0, 32'h304, 6, 4);

    // jump held by stall for two cycles, then consumed once
    br(3'b111, 32'h0, 32'h0, 32'h104, 16'h0, 1'b0);
    jump_target = 32'h00400000;
    stall = 1'b1;
    tick();
    chk("stall1.out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("stall2.out_valid", {31'd0, out_valid}, 32'd0);
    chk("stall2.redirect", {31'd0, redirect}, 32'd0);
    stall = 1'b0;
    tick();
    in_valid = 1'b0;
    out("jump", 1, 1, 1, 32'h00400000, 7, 5);
    chk("jump.s_branch_sat", {30'd0, s_branch_count}, 32'd3);
    tick();
    out("jump_idle", 0, 1, 0, 32'h00400000, 7, 5);
    pred("jump.no_train", 32'h104, 1'b0);

    // killed bne must leave outputs, counters and table alone
    br(3'b010, 32'h1, 32'h2, 32'h108, 16'h0008, 1'b0);
    kill = 1'b1;
    tick();
    kill = 1'b0; in_valid = 1'b0;
    out("kill", 0, 1, 0, 32'h00400000, 7, 5);
    pred("kill.no_train", 32'h108, 1'b0);

    // target wraps past the top of the address space
    br(3'b001, 32'h7, 32'h7, 32'hFFFFFFFC, 16'h0001, 1'b1);
    tick();
    out("wrap", 1, 1, 0, 32'h4, 8, 5);

    br(3'b011, 32'hFFFFFFFF, 32'h0, 32'h400, 16'h0002, 1'b1);
    tick();
    out("blez_neg", 1, 1, 0, 32'h40C, 9, 5);

    br(3'b110, 32'h80000000, 32'h0, 32'h500, 16'h0002, 1'b1);
    tick();
    out("bgez_neg", 1, 0, 1, 32'h504, 10, 6);

    // code 000 with in_valid is not a control instruction
    br(3'b000, 32'h0, 32'h0, 32'h600, 16'h0, 1'b0);
    tick();
    out("none", 0, 0, 0, 32'h504, 10, 6);
    pred("wrap.pred_before_reset", 32'hFFFFFFFC, 1'b1);

    // reset while a taken branch is presented
    br(3'b001, 32'h1, 32'h1, 32'hFFFFFFFC, 16'h0001, 1'b0);
    rst_n = 1'b0;
    tick();
    out("midreset", 0, 0, 0, 32'h0, 0, 0);
    pred("midreset.pred_fc", 32'hFFFFFFFC, 1'b0);
    pred("midreset.pred_100", 32'h100, 1'b0);
    chk("midreset.s_mispredict", {30'd0, s_mispredict_count}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
Parametrised branch resolution unit for the mips32 pipeline, replacing the combinational branch comparator.
- Evaluates full-width register conditions (beq/bne/blez/bgtz/bltz/bgez) and unconditional jumps.
- Computes the branch target and keeps a direct-mapped table of 2-bit saturating predictors, read at fetch and updated at resolve.
- Produces a registered redirect/flush to fetch and saturating branch/mispredict statistics counters.

Parameters:
DATA_W, 32, width of compared register values
PC_W, 32, program counter width
BHT_DEPTH, 16, predictor entries; power of 2, >=2
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
fetch_pc  input  PC_W  PC being fetched, for prediction lookup
pred_taken  output  1  combinational prediction for fetch_pc: counter MSB
in_valid  input  1  resolve-stage instruction valid
stall  input  1  pipeline stall; instruction held, not consumed
kill  input  1  older-stage flush; discards current instruction
code  input  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 jump (j/jal/jr)
rs_val  input  DATA_W  rs operand value
rt_val  input  DATA_W  rt operand value (beq/bne only)
pc  input  PC_W  PC of resolving instruction
imm  input  16  branch offset in words
jump_target  input  PC_W  precomputed j/jal/jr target
pred_in  input  1  prediction made at fetch, carried down the pipe
out_valid  output  1  registered: result below is valid
taken  output  1  registered: branch/jump taken
redirect  output  1  registered: out_valid & mispredict; fetch must load redirect_pc
redirect_pc  output  PC_W  registered correct next PC
branch_count  output  CNT_W  resolved control instructions, saturating
mispredict_count  output  CNT_W  redirects issued, saturating

Behaviour:
- accept = in_valid & ~stall & ~kill & (code != 000). All updates below occur only on accept.
- Conditions:
  - beq: rs==rt; bne: rs!=rt.
  - blez: rs signed <= 0; bgtz: rs signed > 0; bltz: rs[DATA_W-1]; bgez: ~rs[DATA_W-1].
  - Compares use the full DATA_W width.
- Branch target = pc + 4 + (sign_extend(imm) << 2), computed modulo 2^PC_W, so wrap-around is silent. Fall-through = pc + 4, also modulo 2^PC_W.
- Jumps (code 111): always taken; target = jump_target; always mispredicted (fetch never predicts jumps), so redirect is asserted on every accepted jump.
- Conditional branches: mispredict = (taken != pred_in). redirect_pc = taken ? target : pc + 4.
- Latency: one cycle from accept to out_valid/taken/redirect/redirect_pc.
- In a cycle without accept, out_valid = 0 and redirect = 0; taken and redirect_pc hold their previous values.
- Predictor table:
  - Index = pc[log2(BHT_DEPTH)+1:2]; lookup index = fetch_pc[same bits].
  - On accept of a conditional branch: counter +1 if taken (saturate at 3), -1 if not taken (saturate at 0). Jumps do not update the table.
  - Lookup and update of the same index in the same cycle: pred_taken returns the pre-update value.
- Counters:
  - branch_count increments on each accept.
  - mispredict_count increments on each accept that mispredicts.
  - Both saturate at all-ones and never wrap.
- stall and kill together: kill has priority, but neither consumes, so the outcome is identical.
- Reset, synchronous, active-low, effective at the next edge even mid-operation:
  - out_valid = 0, taken = 0, redirect = 0, redirect_pc = 0.
  - Both counters = 0.
  - Every predictor entry = 2'b01 (weakly not-taken), so pred_taken = 0 after reset.
  - A reset must complete for all entries within one cycle.

Test Plan:
- Reset, then fetch_pc = 0x40 -> pred_taken = 0; all registered outputs 0; counters 0.
- beq, rs = rt = 0xDEADBEEF, pc = 0x100, imm = 0xFFFE, pred_in = 0 -> next cycle out_valid = 1, taken = 1, redirect = 1, redirect_pc = 0xFC, mispredict_count = 1.
- Same beq accepted twice more -> entry index 0 reaches 3; fetch_pc = 0x100 gives pred_taken = 1. Then a not-taken resolve -> counter 2, pred_taken still 1.
- bltz, rs = 0x80000000, pred_in = 1 -> taken = 1, redirect = 0. bgtz, rs = 0 -> taken = 0; with pred_in = 0, redirect = 0 and redirect_pc = pc + 4.
- jump, jump_target = 0x00400000, with stall = 1 for 2 cycles then 0 -> out_valid stays 0 during the stall; exactly one redirect to 0x00400000; branch_count +1.
- kill = 1 with a valid bne -> no output, no table or counter change. Set CNT_W = 2 and run 5 mispredicts -> mispredict_count = 3. Assert rst_n = 0 mid-stream -> all state cleared next edge.
